aes_encipher_ctrl: RTL and testbench

- Sequencer for the combinational AES encipher round datapath (round_type INIT=0, MAIN=1, FINAL=2).
- Owns the 128-bit block state register and applies one round per clock.
- Drives round_type and the round index to the datapath and the key memory; captures the new state each cycle.
- Sits between the AES core top (next/ready/result handshake) and the round datapath plus key memory.

---
 rtl/aes_encipher_ctrl_if.sv | 26 ++
 rtl/aes_encipher_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_encipher_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encipher_ctrl_if.sv
// Bus bundle between the AES core top, the encipher controller and the
// round datapath / key memory. The controller uses the slave view; the
// surrounding core (or a bench standing in for it) uses the master view.
interface aes_encipher_ctrl_if;
  logic         next;
  logic [1:0]   keylen;
  logic [127:0] block_in;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;
  logic [3:0]   round;
  logic [1:0]   round_type;
  logic [127:0] round_key;
  logic [127:0] state_out;
  logic [127:0] state_new;

  modport master (
    output next, keylen, block_in, round_key, state_new,
    input  ready, result, result_valid, round, round_type, state_out
  );

  modport slave (
    input  next, keylen, block_in, round_key, state_new,
    output ready, result, result_valid, round, round_type, state_out
  );
endinterface

// File: rtl/aes_encipher_ctrl.sv
// AES encipher round sequencer. Holds the 128-bit block state, steps the
// combinational round datapath through INIT, Nr-1 MAIN rounds and FINAL,
// one round per clock, and presents the round index to the key memory.
// Optional build macro AES_ENC_CTRL_KEY192_EN: when defined, keylen=01 runs
// 12 rounds; when undefined, keylen=01 runs as a 128-bit key (10 rounds).
module aes_encipher_ctrl #(
  parameter int NR128 = 10,
  parameter int NR256 = 14
) (
  input logic             clk,
  input logic             reset_n,
  aes_encipher_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    MAIN  = 2'd2,
    FINAL = 2'd3
  } fsm_t;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  localparam logic [3:0] NR_KEY128 = 4'(NR128);
  localparam logic [3:0] NR_KEY256 = 4'(NR256);
`ifdef AES_ENC_CTRL_KEY192_EN
  localparam logic [3:0] NR_KEY192 = 4'd12;
`else
  localparam logic [3:0] NR_KEY192 = NR_KEY128;
`endif

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [1:0]   keylen_reg, keylen_next;
  logic [127:0] block_reg, block_next;
  logic         ready_reg, ready_next;
  logic         valid_reg, valid_next;

  logic [3:0]   nr;
  logic [3:0]   round_idx;
  logic [1:0]   round_sel;

  // Round count for the key length captured at accept; reserved code runs as 128.
  always_comb begin
    nr = NR_KEY128;
    case (keylen_reg)
      2'b01:   nr = NR_KEY192;
      2'b10:   nr = NR_KEY256;
      default: nr = NR_KEY128;
    endcase
  end

  // State, counter and handshake registers; reset_n aborts any block in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_reg    <= IDLE;
      cnt_reg    <= 4'd0;
      keylen_reg <= 2'b00;
      block_reg  <= 128'd0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
    end else begin
      fsm_reg    <= fsm_next;
      cnt_reg    <= cnt_next;
      keylen_reg <= keylen_next;
      block_reg  <= block_next;
      ready_reg  <= ready_next;
      valid_reg  <= valid_next;
    end
  end

  // Next-state logic and the round index / round type driven to the datapath.
  always_comb begin
    fsm_next    = fsm_reg;
    cnt_next    = cnt_reg;
    keylen_next = keylen_reg;
    block_next  = block_reg;
    ready_next  = ready_reg;
    valid_next  = valid_reg;
    round_idx   = 4'd0;
    round_sel   = RT_INIT;

    case (fsm_reg)
      IDLE: begin
        // Only IDLE listens to next, so a request while busy is simply dropped.
        if (bus.next) begin
          block_next  = bus.block_in;
          keylen_next = bus.keylen;
          ready_next  = 1'b0;
          valid_next  = 1'b0;
          cnt_next    = 4'd0;
          fsm_next    = INIT;
        end
      end
      INIT: begin
        round_idx  = 4'd0;
        round_sel  = RT_INIT;
        block_next = bus.state_new;
        cnt_next   = 4'd1;
        fsm_next   = MAIN;
      end
      MAIN: begin
        round_idx  = cnt_reg;
        round_sel  = RT_MAIN;
        block_next = bus.state_new;
        cnt_next   = cnt_reg + 4'd1;
        if (cnt_reg == nr - 4'd1) begin
          fsm_next = FINAL;
        end
      end
      FINAL: begin
        round_idx  = nr;
        round_sel  = RT_FINAL;
        block_next = bus.state_new;
        ready_next = 1'b1;
        valid_next = 1'b1;
        fsm_next   = IDLE;
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  assign bus.round        = round_idx;
  assign bus.round_type   = round_sel;
  assign bus.state_out    = block_reg;
  assign bus.result       = block_reg;
  assign bus.ready        = ready_reg;
  assign bus.result_valid = valid_reg;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// Bench for aes_encipher_ctrl: models the AES round datapath and the key
// memory, keeps a scoreboard of expected ciphertexts and checks per-cycle
// round sequencing, latency, busy handling and reset behaviour.
module tb_aes_encipher_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  aes_encipher_ctrl_if bus ();

  aes_encipher_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k the value seen at the following negedge is k.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] res;
    int           nr;
    int           acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  sbox [0:255];
  logic [31:0] w    [0:63];
  logic        prev_valid = 1'b0;
  logic [3:0]  last_round = 4'd0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    d = d >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from the GF(2^8) inverse plus the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Key memory contents for a key of nk 32-bit words (left-aligned in key).
  task automatic set_key(input logic [255:0] key, input int nk);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 64; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rkey(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = 128'd0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic [1:0] t);
    case (t)
      2'd0:    return s ^ k;
      2'd1:    return mix(sub_shift(s)) ^ k;
      2'd2:    return sub_shift(s) ^ k;
      default: return s;
    endcase
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s = pt ^ rkey(0);
    for (int r = 1; r < nr; r++) s = aes_round(s, rkey(r), 2'd1);
    return aes_round(s, rkey(nr), 2'd2);
  endfunction

  function automatic int exp_nr(input logic [1:0] kl);
    if (kl == 2'b10) return 14;
`ifdef AES_ENC_CTRL_KEY192_EN
    if (kl == 2'b01) return 12;
`endif
    return 10;
  endfunction

  // Datapath and key memory model; outputs settle half a cycle before the edge.
  always @(negedge clk) begin
    bus.round_key = rkey(int'(bus.round));
    bus.state_new = aes_round(bus.state_out, bus.round_key, bus.round_type);
  end

  // Scoreboard monitor: per-cycle sequencing while busy, pop on result_valid rise.
  always @(negedge clk) begin : mon
    int   d;
    exp_t e;
    logic [1:0] rt;
    if (reset_n) begin
      if (bus.result_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_valid", 128'(bus.result_valid), 128'd0);
        end else begin
          e = q.pop_front();
          d = cyc - e.acc;
          $display("block done: result=%h latency=%0d last_round=%0d", bus.result, d, last_round);
          check_eq("result", bus.result, e.res);
          check_eq("latency", 128'(d), 128'(e.nr + 1));
          check_eq("last_round", 128'(last_round), 128'(e.nr));
          check_eq("done_ready", 128'(bus.ready), 128'd1);
        end
      end else if (q.size() > 0 && cyc >= q[0].acc) begin
        d = cyc - q[0].acc;
        if (d > q[0].nr + 1) begin
          check_eq("valid_timeout", 128'(bus.result_valid), 128'd1);
          void'(q.pop_front());
        end else if (d <= q[0].nr) begin
          rt = (d == 0) ? 2'd0 : ((d == q[0].nr) ? 2'd2 : 2'd1);
          check_eq("busy_ready", 128'(bus.ready), 128'd0);
          check_eq("busy_valid", 128'(bus.result_valid), 128'd0);
          check_eq("round_seq", 128'({bus.round, bus.round_type}), 128'({4'(d), rt}));
        end
      end
      if (!bus.ready) last_round = bus.round;
    end
    prev_valid = bus.result_valid;
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, 128'(bus.ready), 128'd1);
    check_eq({tag, "_valid"}, 128'(bus.result_valid), 128'd0);
    check_eq({tag, "_result"}, bus.result, 128'd0);
    check_eq({tag, "_round"}, 128'(bus.round), 128'd0);
    check_eq({tag, "_type"}, 128'(bus.round_type), 128'd0);
  endtask

  // Called at a negedge: waits for ready, pulses next for one edge, scrambles inputs.
  task automatic send(input logic [127:0] pt, input logic [1:0] kl, input logic [127:0] exp, output int acc);
    for (int i = 0; i < 100 && !bus.ready; i++) @(negedge clk);
    if (!bus.ready) check_eq("ready_wait", 128'(bus.ready), 128'd1);
    bus.next     = 1'b1;
    bus.block_in = pt;
    bus.keylen   = kl;
    acc          = cyc + 1;
    q.push_back('{exp, exp_nr(kl), acc});
    @(negedge clk);
    bus.next     = 1'b0;
    bus.block_in = {$urandom, $urandom, $urandom, $urandom};
    bus.keylen   = ~kl;
  endtask

  task automatic wait_d(input int acc, input int k);
    for (int i = 0; i < 100 && (cyc - acc) != k; i++) @(negedge clk);
    if ((cyc - acc) != k) check_eq("step_wait", 128'(cyc - acc), 128'(k));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check_eq("done_wait", 128'(q.size()), 128'd0);
      q.delete();
    end
  endtask

  initial begin
    int           acc;
    logic [127:0] blk;
    logic [255:0] key;
    logic [1:0]   kl;

    build_sbox();
    set_key(KEY128, 4);
    reset_n      = 1'b0;
    bus.next     = 1'b0;
    bus.keylen   = 2'b00;
    bus.block_in = 128'd0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Known answers for 128, 256 and 192-bit keys
    send(PT, 2'b00, CT_128, acc);
    wait_done();
    set_key(KEY256, 8);
    send(PT, 2'b10, CT_256, acc);
    wait_done();
    set_key(KEY192, 6);
`ifdef AES_ENC_CTRL_KEY192_EN
    send(PT, 2'b01, CT_192, acc);
`else
    send(PT, 2'b01, ref_encrypt(PT, 10), acc);
`endif
    wait_done();

    // next pulsed mid-block with a different block is ignored
    set_key(KEY128, 4);
    send(PT, 2'b00, CT_128, acc);
    wait_d(acc, 5);
    bus.next     = 1'b1;
    bus.block_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.next = 1'b0;
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check_eq("hold_valid", 128'(bus.result_valid), 128'd1);
      check_eq("hold_result", bus.result, CT_128);
      check_eq("hold_ready", 128'(bus.ready), 128'd1);
    end

    // next raised during FINAL and held: taken in IDLE (reserved keylen runs as 128)
    blk = {$urandom, $urandom, $urandom, $urandom};
    send(blk, 2'b11, ref_encrypt(blk, 10), acc);
    wait_d(acc, 10);
    bus.next     = 1'b1;
    bus.block_in = PT;
    bus.keylen   = 2'b00;
    @(negedge clk);
    q.push_back('{CT_128, 10, cyc + 1});
    @(negedge clk);
    bus.next = 1'b0;
    wait_done();

    // Reset during MAIN round 4, then a fresh block
    send(PT, 2'b00, CT_128, acc);
    wait_d(acc, 4);
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    check_idle("midrst");
    reset_n = 1'b1;
    @(negedge clk);
    send(PT, 2'b00, CT_128, acc);
    wait_done();

    // Random keys and blocks against the reference model
    for (int n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl  = n[0] ? 2'b10 : 2'b00;
      set_key(key, kl == 2'b10 ? 8 : 4);
      blk = {$urandom, $urandom, $urandom, $urandom};
      send(blk, kl, ref_encrypt(blk, exp_nr(kl)), acc);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
